// File: rtl/fir_ram_sequencer.sv
// Sequencer for the RAM-based FIR: writes each sample, walks taps, drives MAC flags, strobes capture.
// Optional saturation event counter enabled by defining FIR_SEQ_LIMIT_CNT_EN.
module fir_ram_sequencer #(
    parameter int unsigned TAPS    = 32,
    parameter int unsigned IWIDTH  = 16,
    parameter int unsigned MAC_LAT = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        sample_valid_i,
    input  logic [IWIDTH-1:0]           sample_i,
    output logic                        busy_o,
    output logic                        overrun_o,
    output logic                        smp_we_o,
    output logic [$clog2(TAPS)-1:0]     smp_waddr_o,
    output logic [IWIDTH-1:0]           smp_wdata_o,
    output logic [$clog2(TAPS)-1:0]     smp_raddr_o,
    output logic [$clog2(TAPS)-1:0]     coef_raddr_o,
    output logic                        mac_clr_o,
    output logic                        mac_en_o,
    output logic                        cap_o,
    input  logic                        data_limited_i,
    output logic                        out_valid_o,
    output logic                        out_limited_o,
    output logic [15:0]                 lim_cnt_o
);

    localparam int unsigned AWIDTH     = $clog2(TAPS);
    localparam int unsigned DWIDTH     = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam int unsigned DRAIN_LAST = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;
    localparam logic [AWIDTH-1:0] TAP_LAST = AWIDTH'(TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_MAC,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   k_q, k_d;
    logic [DWIDTH-1:0]   dcnt_q, dcnt_d;
    logic [AWIDTH-1:0]   wptr_q, wptr_d;
    logic [IWIDTH-1:0]   sample_q, sample_d;
    logic [AWIDTH-1:0]   smp_raddr_q, smp_raddr_d;
    logic [AWIDTH-1:0]   coef_raddr_q, coef_raddr_d;
    logic                smp_we_q, smp_we_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
    logic                cap_q, cap_d;
    logic                out_valid_q, out_valid_d;
    logic                out_limited_q, out_limited_d;
    logic                a_en_q, a_en_d;
    logic                a_clr_q, a_clr_d;

    // Next state; every output register is loaded from the next-state view so outputs align with state
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        dcnt_d        = dcnt_q;
        wptr_d        = wptr_q;
        sample_d      = sample_q;
        smp_raddr_d   = smp_raddr_q;
        coef_raddr_d  = coef_raddr_q;
        out_limited_d = out_limited_q;
        smp_we_d      = 1'b0;
        out_valid_d   = 1'b0;
        a_clr_d       = 1'b0;
        overrun_d     = sample_valid_i && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (sample_valid_i) begin
                    sample_d = sample_i;
                    smp_we_d = 1'b1;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d      = S_MAC;
                k_d          = '0;
                smp_raddr_d  = wptr_q;
                coef_raddr_d = '0;
                a_clr_d      = 1'b1;
            end
            S_MAC: begin
                if (k_q == TAP_LAST) begin
                    wptr_d  = (wptr_q == TAP_LAST) ? '0 : wptr_q + AWIDTH'(1);
                    dcnt_d  = '0;
                    state_d = (MAC_LAT == 0) ? S_DONE : S_DRAIN;
                end else begin
                    k_d          = k_q + AWIDTH'(1);
                    coef_raddr_d = k_q + AWIDTH'(1);
                    // Circular walk backwards through the sample RAM
                    smp_raddr_d  = (smp_raddr_q == '0) ? TAP_LAST : smp_raddr_q - AWIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DWIDTH'(DRAIN_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    dcnt_d = dcnt_q + DWIDTH'(1);
                end
            end
            S_DONE: begin
                state_d       = S_IDLE;
                out_valid_d   = 1'b1;
                out_limited_d = data_limited_i;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        cap_d  = (state_d == S_DONE);
        a_en_d = (state_d == S_MAC);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            dcnt_q        <= '0;
            wptr_q        <= '0;
            sample_q      <= '0;
            smp_raddr_q   <= '0;
            coef_raddr_q  <= '0;
            smp_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            cap_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_limited_q <= 1'b0;
            a_en_q        <= 1'b0;
            a_clr_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            dcnt_q        <= dcnt_d;
            wptr_q        <= wptr_d;
            sample_q      <= sample_d;
            smp_raddr_q   <= smp_raddr_d;
            coef_raddr_q  <= coef_raddr_d;
            smp_we_q      <= smp_we_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            cap_q         <= cap_d;
            out_valid_q   <= out_valid_d;
            out_limited_q <= out_limited_d;
            a_en_q        <= a_en_d;
            a_clr_q       <= a_clr_d;
        end
    end

    // Address-phase MAC flags delayed to line up with products at the accumulator
    generate
        if (MAC_LAT == 0) begin : g_nolat
            assign mac_en_o  = a_en_q;
            assign mac_clr_o = a_clr_q;
        end else begin : g_lat
            logic [MAC_LAT-1:0] en_pipe_q, en_pipe_d;
            logic [MAC_LAT-1:0] clr_pipe_q, clr_pipe_d;

            always_comb begin
                en_pipe_d     = en_pipe_q;
                clr_pipe_d    = clr_pipe_q;
                en_pipe_d[0]  = a_en_q;
                clr_pipe_d[0] = a_clr_q;
                for (int i = 1; i < MAC_LAT; i++) begin
                    en_pipe_d[i]  = en_pipe_q[i-1];
                    clr_pipe_d[i] = clr_pipe_q[i-1];
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    en_pipe_q  <= '0;
                    clr_pipe_q <= '0;
                end else begin
                    en_pipe_q  <= en_pipe_d;
                    clr_pipe_q <= clr_pipe_d;
                end
            end

            assign mac_en_o  = en_pipe_q[MAC_LAT-1];
            assign mac_clr_o = clr_pipe_q[MAC_LAT-1];
        end
    endgenerate

`ifdef FIR_SEQ_LIMIT_CNT_EN
    logic [15:0] lim_cnt_q, lim_cnt_d;

    // Saturating count of captures that the output processor flagged as limited
    always_comb begin
        lim_cnt_d = lim_cnt_q;
        if (cap_q && data_limited_i && (lim_cnt_q != 16'hFFFF)) begin
            lim_cnt_d = lim_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lim_cnt_q <= '0;
        end else begin
            lim_cnt_q <= lim_cnt_d;
        end
    end

    assign lim_cnt_o = lim_cnt_q;
`else
    assign lim_cnt_o = 16'd0;
`endif

    assign busy_o        = busy_q;
    assign overrun_o     = overrun_q;
    assign smp_we_o      = smp_we_q;
    assign smp_waddr_o   = wptr_q;
    assign smp_wdata_o   = sample_q;
    assign smp_raddr_o   = smp_raddr_q;
    assign coef_raddr_o  = coef_raddr_q;
    assign cap_o         = cap_q;
    assign out_valid_o   = out_valid_q;
    assign out_limited_o = out_limited_q;

endmodule

// File: tb/tb_fir_ram_sequencer.sv
// Directed self-checking bench for fir_ram_sequencer: TAPS=4/MAC_LAT=2 and TAPS=5/MAC_LAT=0 instances.
module tb_fir_ram_sequencer;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [15:0] sample;
    logic        data_limited;

    logic        busy, overrun, smp_we, mac_clr, mac_en, cap, out_valid, out_limited;
    logic [1:0]  smp_waddr, smp_raddr, coef_raddr;
    logic [15:0] smp_wdata, lim_cnt;

    logic        sample_valid2;
    logic [15:0] sample2;
    logic        busy2, overrun2, smp_we2, mac_clr2, mac_en2, cap2, out_valid2, out_limited2;
    logic [2:0]  smp_waddr2, smp_raddr2, coef_raddr2;
    logic [15:0] smp_wdata2, lim_cnt2;

    int n_cmp = 0;
    int n_err = 0;
    int lim_exp;

    fir_ram_sequencer #(.TAPS(4), .IWIDTH(16), .MAC_LAT(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .sample_valid_i(sample_valid), .sample_i(sample),
        .busy_o(busy), .overrun_o(overrun), .smp_we_o(smp_we), .smp_waddr_o(smp_waddr),
        .smp_wdata_o(smp_wdata), .smp_raddr_o(smp_raddr), .coef_raddr_o(coef_raddr),
        .mac_clr_o(mac_clr), .mac_en_o(mac_en), .cap_o(cap), .data_limited_i(data_limited),
        .out_valid_o(out_valid), .out_limited_o(out_limited), .lim_cnt_o(lim_cnt)
    );

    fir_ram_sequencer #(.TAPS(5), .IWIDTH(16), .MAC_LAT(0)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .sample_valid_i(sample_valid2), .sample_i(sample2),
        .busy_o(busy2), .overrun_o(overrun2), .smp_we_o(smp_we2), .smp_waddr_o(smp_waddr2),
        .smp_wdata_o(smp_wdata2), .smp_raddr_o(smp_raddr2), .coef_raddr_o(coef_raddr2),
        .mac_clr_o(mac_clr2), .mac_en_o(mac_en2), .cap_o(cap2), .data_limited_i(data_limited),
        .out_valid_o(out_valid2), .out_limited_o(out_limited2), .lim_cnt_o(lim_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_we"}, 32'(smp_we), 0);
        chk({tag, "_waddr"}, 32'(smp_waddr), 0);
        chk({tag, "_wdata"}, 32'(smp_wdata), 0);
        chk({tag, "_raddr"}, 32'(smp_raddr), 0);
        chk({tag, "_coef"}, 32'(coef_raddr), 0);
        chk({tag, "_en"}, 32'(mac_en), 0);
        chk({tag, "_clr"}, 32'(mac_clr), 0);
        chk({tag, "_cap"}, 32'(cap), 0);
        chk({tag, "_ovalid"}, 32'(out_valid), 0);
        chk({tag, "_olim"}, 32'(out_limited), 0);
        chk({tag, "_limcnt"}, 32'(lim_cnt), 0);
    endtask

    // One full TAPS=4/MAC_LAT=2 sequence; entered in the cycle that raises sample_valid, leaves in the out_valid cycle
    task automatic run_seq(input logic [15:0] s, input int wa, input logic dl, input int ovr_at);
        sample_valid = 1'b1;
        sample       = s;
        data_limited = ~dl;
        for (int c = 1; c <= 9; c++) begin
            step();
            sample_valid = (c == ovr_at);
            sample       = (c == ovr_at) ? 16'hDEAD : 16'h0000;
            data_limited = (c == 8) ? dl : ~dl;
            chk("we", 32'(smp_we), 32'(c == 1));
            if (c == 1) begin
                chk("waddr", 32'(smp_waddr), 32'(wa));
                chk("wdata", 32'(smp_wdata), 32'(s));
            end
            if (c >= 2 && c <= 5) begin
                chk("raddr", 32'(smp_raddr), 32'((wa + 4 - (c - 2)) % 4));
                chk("coef", 32'(coef_raddr), 32'(c - 2));
            end
            if (c >= 6 && c <= 8) begin
                chk("raddr_hold", 32'(smp_raddr), 32'((wa + 1) % 4));
                chk("coef_hold", 32'(coef_raddr), 3);
            end
            chk("mac_en", 32'(mac_en), 32'(c >= 4 && c <= 7));
            chk("mac_clr", 32'(mac_clr), 32'(c == 4));
            chk("cap", 32'(cap), 32'(c == 8));
            chk("out_valid", 32'(out_valid), 32'(c == 9));
            chk("busy", 32'(busy), 32'(c <= 8));
            chk("overrun", 32'(overrun), 32'(c == ovr_at + 1));
            if (c == 9) chk("out_limited", 32'(out_limited), 32'(dl));
        end
        sample_valid = 1'b0;
        data_limited = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        sample_valid  = 1'b0;
        sample        = '0;
        data_limited  = 1'b0;
        sample_valid2 = 1'b0;
        sample2       = '0;

        // Reset state
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Single sample after reset
        run_seq(16'h0123, 0, 1'b0, -10);
        step();
        step();

        // Five back-to-back samples with write pointer wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        run_seq(16'h1111, 0, 1'b0, -10);
        run_seq(16'h2222, 1, 1'b0, -10);
        run_seq(16'h3333, 2, 1'b0, -10);
        run_seq(16'h4444, 3, 1'b0, -10);
        run_seq(16'h5555, 0, 1'b0, -10);

        // Sample arriving mid-sequence is dropped
        run_seq(16'h6666, 1, 1'b0, 3);
        step();

        // Reset in cycle 5 of a sequence
        sample_valid = 1'b1;
        sample       = 16'h7777;
        for (int c = 1; c <= 5; c++) begin
            step();
            sample_valid = 1'b0;
        end
        rst = 1'b1;
        step();
        chk_all_zero("midrst");
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("midrst_no_ovalid", 32'(out_valid), 0);
            chk("midrst_idle", 32'(busy), 0);
        end
        run_seq(16'h8888, 0, 1'b0, -10);

        // Three limited captures
        run_seq(16'h9999, 1, 1'b1, -10);
        run_seq(16'hAAAA, 2, 1'b1, -10);
        run_seq(16'hBBBB, 3, 1'b1, -10);
`ifdef FIR_SEQ_LIMIT_CNT_EN
        lim_exp = 3;
`else
        lim_exp = 0;
`endif
        chk("lim_cnt", 32'(lim_cnt), 32'(lim_exp));
        step();

        // TAPS=5, MAC_LAT=0: six back-to-back samples, period 8
        for (int n = 0; n < 6; n++) begin
            sample_valid2 = 1'b1;
            sample2       = 16'(16'h0100 + n);
            for (int c = 1; c <= 8; c++) begin
                step();
                sample_valid2 = 1'b0;
                chk("t5_we", 32'(smp_we2), 32'(c == 1));
                if (c == 1) chk("t5_waddr", 32'(smp_waddr2), 32'(n % 5));
                if (c >= 2 && c <= 6) begin
                    chk("t5_raddr", 32'(smp_raddr2), 32'(((n % 5) + 5 - (c - 2)) % 5));
                end
                chk("t5_raddr_range", 32'(smp_raddr2 <= 3'd4), 1);
                chk("t5_mac_en", 32'(mac_en2), 32'(c >= 2 && c <= 6));
                chk("t5_mac_clr", 32'(mac_clr2), 32'(c == 2));
                chk("t5_cap", 32'(cap2), 32'(c == 7));
                chk("t5_out_valid", 32'(out_valid2), 32'(c == 8));
                chk("t5_overrun", 32'(overrun2), 0);
            end
        end
        sample_valid2 = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
